// File: rtl/fir_engine_ctrl_pkg.sv
// Shared types and constants for the FIR engine control path.
package fir_engine_ctrl_pkg;

    localparam int FIR_N_COEFF     = 4;
    localparam int FIR_COEFF_WIDTH = 32;
    localparam int FIR_CNT_WIDTH   = 32;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERROR
    } ctrl_state_t;

    typedef logic [FIR_N_COEFF-1:0][FIR_COEFF_WIDTH-1:0] coeff_array_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic                     err;
        logic [FIR_CNT_WIDTH-1:0] cnt;
    } ctrl_flags_t;

    // The kernel is considered live (started or still emitting) in these states.
    function automatic logic is_active(ctrl_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/fir_ctrl_watchdog.sv
// Stall watchdog: loadable up-counter with soft clear and a terminal-count flag.
module fir_ctrl_watchdog #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    assign tc_o = &count_q;

    // Saturates at terminal count so the flag cannot wrap back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (en_i && !tc_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fir_engine_ctrl.sv
// Job sequencer for the FIR HLS kernel: latches coefficients, drives ap_start,
// counts output handshakes and reports busy/done/error.
module fir_engine_ctrl
    import fir_engine_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = FIR_CNT_WIDTH,
    parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter int N_COEFF     = FIR_N_COEFF,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           trigger_i,
    input  logic                           clear_i,
    input  logic [CNT_WIDTH-1:0]           len_i,
    input  logic [N_COEFF*COEFF_WIDTH-1:0] coeff_i,
    output logic [N_COEFF*COEFF_WIDTH-1:0] coeff_o,
    output logic                           k_start_o,
    input  logic                           k_done_i,
    input  logic                           k_idle_i,
    input  logic                           k_ready_i,
    input  logic                           in_hs_i,
    input  logic                           out_hs_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [CNT_WIDTH-1:0]           cnt_o
);

    ctrl_state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]           len_q;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [N_COEFF*COEFF_WIDTH-1:0] coeff_q;
    logic                           k_start_q, k_start_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           accept;
    logic                           hs_last;
    logic                           wd_load;
    logic                           wd_tc;
    logic                           k_ready_q;

    assign accept  = (state_q == IDLE) && trigger_i && !clear_i;
    assign hs_last = out_hs_i && (cnt_q == len_q - CNT_WIDTH'(1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear_i beats everything but reset.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (trigger_i) state_d = (len_i == '0) ? DONE : RUN;
                RUN:     if (wd_tc) state_d = ERROR;
                         else if (hs_last) state_d = DRAIN;
                DRAIN:   if (wd_tc) state_d = ERROR;
                         else if (k_idle_i || k_done_i) state_d = DONE;
                DONE:    state_d = IDLE;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: flags follow the upcoming state so they are registered
    // yet aligned with it; the counter saturates only in DRAIN (overrun).
    always_comb begin
        k_start_d = (state_d == RUN);
        busy_d    = is_active(state_d);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERROR);
        cnt_d     = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE:    if (trigger_i) cnt_d = '0;
                RUN:     if (out_hs_i) cnt_d = cnt_q + CNT_WIDTH'(1);
                DRAIN:   if (out_hs_i && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: the coefficient and length registers are reset too, so the kernel
    // never sees X coefficients before the first job.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_start_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            coeff_q   <= '0;
        end else begin
            k_start_q <= k_start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            if (accept && (len_i != '0)) begin
                len_q   <= len_i;
                coeff_q <= coeff_i;
            end
        end
    end

    // Any stream activity or state change restarts the stall window.
    assign wd_load = (state_d != state_q) || in_hs_i || out_hs_i;

    fir_ctrl_watchdog #(
        .WIDTH (TIMEOUT_W)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .load_i  (wd_load),
        .value_i ('0),
        .en_i    (is_active(state_q)),
        .tc_o    (wd_tc)
    );

    assign coeff_o   = coeff_q;
    assign k_start_o = k_start_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign cnt_o     = cnt_q;

    // The kernel may only report ap_ready while a job is live.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_ready_q <= 1'b0;
        end else begin
            k_ready_q <= k_ready_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && k_ready_i && !k_ready_q) begin
            assert (is_active(state_q));
        end
    end

endmodule
